// File: rtl/tetris_input_ctrl.sv
// Turns ps2_keyboard level key state into one-cycle Tetris action pulses,
// with DAS/ARR auto-shift for horizontal moves and a fixed soft-drop repeat.
module tetris_input_ctrl #(
  parameter int unsigned DAS_CYCLES  = 17_000_000,
  parameter int unsigned ARR_CYCLES  = 5_000_000,
  parameter int unsigned SOFT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  output logic       act_left,
  output logic       act_right,
  output logic       act_rot_cw,
  output logic       act_rot_ccw,
  output logic       act_soft,
  output logic       act_hard,
  output logic [5:0] keys_held
);

  localparam int unsigned H_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int unsigned HW    = ($clog2(H_MAX) < 1) ? 1 : $clog2(H_MAX);
  localparam int unsigned SW    = ($clog2(SOFT_CYCLES) < 1) ? 1 : $clog2(SOFT_CYCLES);

  localparam logic [HW-1:0] DAS_LAST  = HW'(DAS_CYCLES - 1);
  localparam logic [HW-1:0] ARR_LAST  = HW'(ARR_CYCLES - 1);
  localparam logic [SW-1:0] SOFT_LAST = SW'(SOFT_CYCLES - 1);

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} hstate_e;
  typedef enum logic {DIR_L, DIR_R} dir_e;

  logic [8:0]    prev_q;
  logic [5:0]    held_q, held_d;
  hstate_e       hstate_q, hstate_d;
  dir_e          dir_q, dir_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [5:0]    act_q, act_d;

  logic [5:0] kmask;
  logic       evt, make_new, brk, h_pulse, s_pulse;
  logic [5:0] dir_mask, opp_mask;

  // Bit order matches keys_held: {hard, soft, rot_ccw, rot_cw, right, left}
  always_comb begin
    kmask = '0;
    case (scan_code)
      8'h6B:   kmask = 6'b000001;
      8'h74:   kmask = 6'b000010;
      8'h75:   kmask = 6'b000100;
      8'h1A:   kmask = 6'b001000;
      8'h72:   kmask = 6'b010000;
      8'h29:   kmask = 6'b100000;
      default: kmask = '0;
    endcase
  end

  assign evt      = ({scan_code, make_break} != prev_q);
  assign make_new = evt && (|kmask) && make_break  && ((held_q & kmask) == '0);
  assign brk      = evt && (|kmask) && !make_break && (|(held_q & kmask));
  assign dir_mask = (dir_q == DIR_L) ? 6'b000001 : 6'b000010;
  assign opp_mask = (dir_q == DIR_L) ? 6'b000010 : 6'b000001;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      held_q   <= '0;
      hstate_q <= H_IDLE;
      dir_q    <= DIR_L;
      hcnt_q   <= '0;
      scnt_q   <= '0;
      act_q    <= '0;
    end else begin
      prev_q   <= {scan_code, make_break};
      held_q   <= held_d;
      hstate_q <= hstate_d;
      dir_q    <= dir_d;
      hcnt_q   <= hcnt_d;
      scnt_q   <= scnt_d;
      act_q    <= act_d;
    end
  end

  always_comb begin
    held_d   = held_q;
    hstate_d = hstate_q;
    dir_d    = dir_q;
    hcnt_d   = hcnt_q;
    scnt_d   = scnt_q;
    h_pulse  = 1'b0;
    s_pulse  = 1'b0;

    if (make_new) held_d = held_q | kmask;
    if (brk)      held_d = held_q & ~kmask;

    // New press beats a dir release, which beats any terminal count this cycle
    if (make_new && (kmask[0] || kmask[1])) begin
      h_pulse  = 1'b1;
      dir_d    = kmask[0] ? DIR_L : DIR_R;
      hstate_d = H_DAS;
      hcnt_d   = '0;
    end else if (brk && (hstate_q != H_IDLE) && (kmask == dir_mask)) begin
      hcnt_d = '0;
      if (|(held_q & opp_mask)) begin
        dir_d    = (dir_q == DIR_L) ? DIR_R : DIR_L;
        hstate_d = H_DAS;
      end else begin
        hstate_d = H_IDLE;
      end
    end else begin
      case (hstate_q)
        H_DAS: begin
          if (hcnt_q == DAS_LAST) begin
            h_pulse  = 1'b1;
            hstate_d = H_ARR;
            hcnt_d   = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        H_ARR: begin
          if (hcnt_q == ARR_LAST) begin
            h_pulse = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: hcnt_d = '0;
      endcase
    end

    if (make_new && kmask[4]) begin
      s_pulse = 1'b1;
      scnt_d  = '0;
    end else if (held_q[4] && !(brk && kmask[4])) begin
      if (scnt_q == SOFT_LAST) begin
        s_pulse = 1'b1;
        scnt_d  = '0;
      end else begin
        scnt_d = scnt_q + SW'(1);
      end
    end else begin
      scnt_d = '0;
    end
  end

  always_comb begin
    act_d    = '0;
    act_d[0] = h_pulse && (dir_d == DIR_L);
    act_d[1] = h_pulse && (dir_d == DIR_R);
    act_d[2] = make_new && kmask[2];
    act_d[3] = make_new && kmask[3];
    act_d[4] = s_pulse;
    act_d[5] = make_new && kmask[5];
  end

  assign act_left    = act_q[0];
  assign act_right   = act_q[1];
  assign act_rot_cw  = act_q[2];
  assign act_rot_ccw = act_q[3];
  assign act_soft    = act_q[4];
  assign act_hard    = act_q[5];
  assign keys_held   = held_q;

endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Converts the level-style key state from `ps2_keyboard` (`current_scan_code`, `current_make_break`) into one-cycle Tetris action pulses for the game FSM. Sits directly downstream of `ps2_keyboard`, in the same `clk` domain. Tracks which mapped keys are held. Generates delayed auto-shift (DAS) and auto-repeat (ARR) for horizontal moves, plus a fixed repeat for soft drop.

## Interface
Parameters:
- `DAS_CYCLES`, default 17_000_000: cycles from the initial horizontal pulse to the first auto-repeat pulse (170 ms at 100 MHz).
- `ARR_CYCLES`, default 5_000_000: cycles between horizontal auto-repeat pulses.
- `SOFT_CYCLES`, default 5_000_000: cycles between soft-drop repeat pulses.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `scan_code`  in  8  from `ps2_keyboard.current_scan_code`.
- `make_break`  in  1  from `ps2_keyboard.current_make_break`; 1 = make, 0 = break.
- `act_left`, `act_right`, `act_rot_cw`, `act_rot_ccw`, `act_soft`, `act_hard`  out  1 each  registered one-cycle action pulses.
- `keys_held`  out  6  held bitmap {hard, soft, rot_ccw, rot_cw, right, left}, with left as bit 0.

## Operation
- Key map: left 0x6B, right 0x74, rot_cw 0x75, rot_ccw 0x1A, soft 0x72, hard 0x29. All other codes are ignored.
- Event detection: register `prev = {scan_code, make_break}`, which resets to {0x00, 0}. An event occurs when the input pair differs from `prev`. `prev` updates every cycle.
- Make of an unheld mapped key: set its held bit and apply the action below.
- Make of an already-held key: no effect. This covers keyboard typematic resends after another key's event.
- Break of a held key: clear its held bit. Break of an unheld key: no effect.
- Rotate and hard drop: exactly one pulse per make. They never repeat.
- Soft drop:
  - Pulse on make, then clear `soft_cnt`.
  - While held, pulse each time `soft_cnt` reaches `SOFT_CYCLES-1`, then wrap `soft_cnt` to 0.
  - On release, stop immediately.
- Horizontal FSM has states `H_IDLE`, `H_DAS`, `H_ARR`, with `dir` ∈ {L, R} and `h_cnt`.
  - Make of left/right (from any state): pulse that direction, set `dir` to it, go to `H_DAS`, set `h_cnt = 0`. The newest direction always wins.
  - `H_DAS` with `h_cnt == DAS_CYCLES-1`: pulse `dir`, go to `H_ARR`, set `h_cnt = 0`. Otherwise increment `h_cnt`.
  - `H_ARR` with `h_cnt == ARR_CYCLES-1`: pulse `dir`, set `h_cnt = 0`. Otherwise increment `h_cnt`.
  - Break of `dir` key with the opposite key still held: set `dir` to the opposite, go to `H_DAS`, set `h_cnt = 0`. No immediate pulse.
  - Break of `dir` key with the opposite key not held: go to `H_IDLE`.
  - Break of the non-`dir` key: clear its held bit only.
- Counter widths: `$clog2` of the largest relevant parameter, minimum 1. Parameters must be ≥ 2.

## Timing
- Reset (`rst` = 0): all `act_*` = 0, `keys_held` = 0, FSM = `H_IDLE`, counters = 0, `prev` = {0x00, 0}. These take effect asynchronously.
- After reset release, a still-present mapped make pair on the inputs counts as a new press.
- Latency:
  - An event pair is sampled at edge N.
  - The press/release pulse and the `keys_held` update are visible after edge N.
  - Each pulse is high for exactly one cycle.
- Repeat pulse timing:
  - First horizontal repeat: `DAS_CYCLES` cycles after the initial pulse.
  - Later horizontal repeats: every `ARR_CYCLES` cycles.
  - Soft-drop repeats: every `SOFT_CYCLES` cycles.
- Simultaneous events:
  - A new horizontal make in the same cycle as a repeat terminal count: only the new direction pulses.
  - A break of `dir` in the same cycle as a terminal count: no pulse.
  - Soft and horizontal pulses may coincide.
  - At most one event-driven pulse occurs per cycle.

## Test plan
Bench parameters: DAS=20, ARR=5, SOFT=4, with `rst` pulsed low at start.
- Reset: all `act_*` = 0 and `keys_held` = 0 during and after reset. Asserting `rst` low mid-ARR forces outputs to 0 within the same cycle.
- Hold left: drive {0x6B, 1} for 50 cycles, then {0x6B, 0}.
  - `act_left` pulses at t = 1, 21, 26, 31, 36, 41, 46.
  - No pulses after the break; `keys_held[0]` clears.
- Rotate: {0x75, 1} held for 100 cycles gives exactly one `act_rot_cw`. Then {0x1C, 1}, then {0x75, 1} again gives no second pulse, because rot_cw is still held.
- Direction priority: left held in `H_ARR`, then {0x74, 1}.
  - `act_right` pulses next cycle; no further `act_left`.
  - Break right: no immediate pulse; `act_left` pulses 20 cycles later.
- Soft and hard drop:
  - {0x72, 1} for 10 cycles: `act_soft` at t = 1, 5, 9.
  - {0x29, 1} then {0x29, 0}: one `act_hard`.
  - {0x1C, 1}: no pulses.
